// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port owner: fills the buffer from reset or a clear, then shares the port between PPU pixels and the host.
// Latency: pixel to fb 3 cycles, host to fb 1 cycle. Backpressure: pixels drop on full FIFO (sticky flag); host waits on host_ready.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    input  logic          pop_rdy,
    output logic          head_vld,
    output logic [DW-1:0] head_dat,
    output logic          full
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        head_vld = (wptr_q != rptr_q);
        full     = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
        do_pop   = pop_rdy && head_vld;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        do_push  = push_vld && (!full || do_pop);
        head_dat = mem_q[rptr_q[AW-1:0]];
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_ONE;
            if (do_pop)  rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
endmodule

module fb_write_arbiter #(
    parameter int          WIDTH         = 240,
    parameter int          HEIGHT        = 160,
    parameter int          FIFO_DEPTH    = 4,
    parameter int          HOST_MAX_WAIT = 16,
    parameter logic [17:0] RESET_COLOR   = 18'h20820
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear_req,
    input  logic [17:0] clear_color,
    output logic        busy,
    input  logic        pix_we,
    input  logic [7:0]  pix_x,
    input  logic [7:0]  pix_y,
    input  logic [17:0] pix_data,
    output logic        pix_overflow,
    input  logic        host_valid,
    input  logic [15:0] host_addr,
    input  logic [17:0] host_data,
    output logic        host_ready,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [17:0] fb_wdata
);
    localparam logic [15:0]   FB_WORDS  = 16'(WIDTH * HEIGHT);
    localparam logic [15:0]   LAST_ADDR = 16'(WIDTH * HEIGHT - 1);
    localparam logic [15:0]   WIDTH16   = 16'(WIDTH);
    localparam logic [15:0]   HEIGHT16  = 16'(HEIGHT);
    localparam logic [15:0]   ADDR_ONE  = 16'd1;
    localparam int            WW        = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(HOST_MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

    typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [17:0] data;
    } fb_wr_t;

    state_t        state_q, state_d;
    logic [15:0]   fill_addr_q, fill_addr_d;
    logic [17:0]   fill_color_q, fill_color_d;
    logic          s1_vld_q, s1_vld_d;
    fb_wr_t        s1_q, s1_d;
    logic          overflow_q, overflow_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          fb_we_q, fb_we_d;
    logic [15:0]   fb_addr_q, fb_addr_d;
    logic [17:0]   fb_wdata_q, fb_wdata_d;

    logic          run, grant_ok, forced, host_grant, fifo_pop, pix_in_range;
    logic          fifo_head_vld, fifo_full;
    fb_wr_t        fifo_head;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    ($bits(fb_wr_t))
    ) u_pix_fifo (
        .clk      (clk),
        .rst_n    (resetn),
        .flush    (clear_req),
        .push_vld (s1_vld_q),
        .push_dat (s1_q),
        .pop_rdy  (fifo_pop),
        .head_vld (fifo_head_vld),
        .head_dat (fifo_head),
        .full     (fifo_full)
    );

    always_comb begin
        run          = (state_q == S_RUN);
        grant_ok     = run && !clear_req;
        // A host that has waited long enough pre-empts the pixel stream for one slot.
        forced       = host_valid && (wait_cnt_q == WAIT_MAX);
        host_grant   = grant_ok && host_valid && (forced || !fifo_head_vld);
        fifo_pop     = grant_ok && !host_grant && fifo_head_vld;
        pix_in_range = ({8'd0, pix_x} < WIDTH16) && ({8'd0, pix_y} < HEIGHT16);

        state_d      = state_q;
        fill_addr_d  = fill_addr_q;
        fill_color_d = fill_color_q;
        s1_vld_d     = grant_ok && pix_we && pix_in_range;
        s1_d.addr    = 16'(pix_y) * WIDTH16 + {8'd0, pix_x};
        s1_d.data    = pix_data;
        overflow_d   = overflow_q || (s1_vld_q && fifo_full && !fifo_pop);
        wait_cnt_d   = (grant_ok && host_valid && !host_grant) ? wait_cnt_q + WAIT_ONE : '0;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;

        if (clear_req) begin
            state_d      = S_FILL;
            fill_addr_d  = '0;
            fill_color_d = clear_color;
            overflow_d   = 1'b0;
        end else if (!run) begin
            fb_we_d     = 1'b1;
            fb_addr_d   = fill_addr_q;
            fb_wdata_d  = fill_color_q;
            fill_addr_d = fill_addr_q + ADDR_ONE;
            if (fill_addr_q == LAST_ADDR) state_d = S_RUN;
        end else if (host_grant) begin
            // Out-of-range host words complete the handshake but never reach the BRAM.
            fb_we_d    = (host_addr < FB_WORDS);
            fb_addr_d  = host_addr;
            fb_wdata_d = host_data;
        end else if (fifo_pop) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = fifo_head.addr;
            fb_wdata_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_FILL;
            fill_addr_q  <= '0;
            fill_color_q <= RESET_COLOR;
            s1_vld_q     <= 1'b0;
            s1_q         <= '0;
            overflow_q   <= 1'b0;
            wait_cnt_q   <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            fill_addr_q  <= fill_addr_d;
            fill_color_q <= fill_color_d;
            s1_vld_q     <= s1_vld_d;
            s1_q         <= s1_d;
            overflow_q   <= overflow_d;
            wait_cnt_q   <= wait_cnt_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
        end
    end

    assign busy         = (state_q == S_FILL);
    assign host_ready   = host_grant;
    assign pix_overflow = overflow_q;
    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_wdata     = fb_wdata_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: fill, pixel/host arbitration, clears and reset.
module tb_fb_write_arbiter;
    localparam logic [17:0] RESET_COLOR = 18'h20820;
    localparam logic [17:0] HOST_TAG    = 18'h15555;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear_req;
    logic [17:0] clear_color;
    logic        busy;
    logic        pix_we;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [17:0] pix_data;
    logic        pix_overflow;
    logic        host_valid;
    logic [15:0] host_addr;
    logic [17:0] host_data;
    logic        host_ready;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [17:0] fb_wdata;

    int vec_cnt = 0;
    int err_cnt = 0;
    int host_first, pix_seen, host_seen, order_bad, last_pix;

    fb_write_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .busy         (busy),
        .pix_we       (pix_we),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_data     (pix_data),
        .pix_overflow (pix_overflow),
        .host_valid   (host_valid),
        .host_addr    (host_addr),
        .host_data    (host_data),
        .host_ready   (host_ready),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect();
        if (fb_we === 1'b1) begin
            if (fb_wdata === HOST_TAG) host_seen++;
            else begin
                if (int'(fb_wdata) <= last_pix || fb_addr !== 16'(720 + int'(fb_wdata) - 'h100)) order_bad++;
                last_pix = int'(fb_wdata);
                pix_seen++;
            end
        end
    endtask

    // Pixels on row 3 every cycle; the host joins once the FIFO is non-empty.
    task automatic drive_contention(input int n);
        host_first = -1; pix_seen = 0; host_seen = 0; order_bad = 0; last_pix = 'h0FF;
        for (int i = 0; i < n; i++) begin
            pix_we = 1'b1; pix_x = 8'(i); pix_y = 8'd3; pix_data = 18'(32'h100 + i);
            if (i == 4) begin host_valid = 1'b1; host_addr = 16'd38000; host_data = HOST_TAG; end
            @(negedge clk);
            if (host_ready === 1'b1 && host_first < 0) host_first = i;
            tick();
            collect();
        end
        pix_we = 1'b0; host_valid = 1'b0;
        repeat (10) begin tick(); collect(); end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        host_valid = 1'b1; host_addr = 16'd10; host_data = 18'd1;
        repeat (3) tick();
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL reset_busy: got %b want 1", busy); end
        vec_cnt++; if (fb_we !== 1'b0) begin err_cnt++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
        vec_cnt++; if (fb_addr !== 16'd0) begin err_cnt++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
        vec_cnt++; if (fb_wdata !== 18'd0) begin err_cnt++; $display("FAIL reset_fb_wdata: got %h want 0", fb_wdata); end
        vec_cnt++; if (pix_overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %b want 0", pix_overflow); end
        vec_cnt++; if (host_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_host_ready: got %b want 0", host_ready); end
        host_valid = 1'b0;
    endtask

    task automatic test_fill_after_reset();
        int  cnt, bad, any_we;
        logic prev_busy, last_busy;
        bit  done;
        cnt = 0; bad = 0; any_we = 0; done = 0; prev_busy = 1'bx; last_busy = 1'bx;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 40000 && !done; i++) begin
            tick();
            if (fb_we === 1'b1) begin
                if (fb_addr !== cnt[15:0] || fb_wdata !== RESET_COLOR) bad++;
                if (fb_addr === 16'd38398) prev_busy = busy;
                if (fb_addr === 16'd38399) last_busy = busy;
                cnt++;
            end else if (cnt > 0) done = 1;
            if (cnt == 100) begin
                host_valid = 1'b1; host_addr = 16'd5; host_data = 18'd1;
                pix_we = 1'b1; pix_x = 8'd1; pix_y = 8'd1; pix_data = 18'd3;
                @(negedge clk);
                vec_cnt++; if (host_ready !== 1'b0) begin err_cnt++; $display("FAIL fill_host_ready: got %b want 0", host_ready); end
            end
            if (cnt == 101) begin host_valid = 1'b0; pix_we = 1'b0; end
        end
        vec_cnt++; if (cnt != 38400) begin err_cnt++; $display("FAIL fill_count: got %0d want 38400", cnt); end
        vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL fill_sequence: got %0d bad writes want 0", bad); end
        vec_cnt++; if (prev_busy !== 1'b1) begin err_cnt++; $display("FAIL fill_busy_before_end: got %b want 1", prev_busy); end
        vec_cnt++; if (last_busy !== 1'b0) begin err_cnt++; $display("FAIL fill_busy_falls: got %b want 0", last_busy); end
        repeat (4) begin tick(); if (fb_we !== 1'b0) any_we++; end
        vec_cnt++; if (any_we != 0) begin err_cnt++; $display("FAIL fill_pixel_ignored: got %0d writes want 0", any_we); end
    endtask

    task automatic test_pixel_single();
        pix_we = 1'b1; pix_x = 8'd5; pix_y = 8'd2; pix_data = 18'h3F000;
        tick(); pix_we = 1'b0;
        vec_cnt++; if (fb_we !== 1'b0) begin err_cnt++; $display("FAIL pix_lat1: got %b want 0", fb_we); end
        tick();
        vec_cnt++; if (fb_we !== 1'b0) begin err_cnt++; $display("FAIL pix_lat2: got %b want 0", fb_we); end
        tick();
        vec_cnt++; if (fb_we !== 1'b1 || fb_addr !== 16'd485 || fb_wdata !== 18'h3F000) begin
            err_cnt++; $display("FAIL pix_write: got we=%b addr=%0d data=%h want 1/485/3f000", fb_we, fb_addr, fb_wdata); end
        tick();
        vec_cnt++; if (fb_we !== 1'b0) begin err_cnt++; $display("FAIL pix_single_once: got %b want 0", fb_we); end
        // Bottom-right corner: largest legal address.
        pix_we = 1'b1; pix_x = 8'd239; pix_y = 8'd159; pix_data = 18'h00ABC;
        tick(); pix_we = 1'b0;
        tick(); tick();
        vec_cnt++; if (fb_we !== 1'b1 || fb_addr !== 16'd38399 || fb_wdata !== 18'h00ABC) begin
            err_cnt++; $display("FAIL pix_corner: got we=%b addr=%0d data=%h want 1/38399/00abc", fb_we, fb_addr, fb_wdata); end
        tick();
    endtask

    task automatic test_host_single();
        host_valid = 1'b1; host_addr = 16'd100; host_data = 18'd7;
        @(negedge clk);
        vec_cnt++; if (host_ready !== 1'b1) begin err_cnt++; $display("FAIL host_ready: got %b want 1", host_ready); end
        tick(); host_valid = 1'b0;
        vec_cnt++; if (fb_we !== 1'b1 || fb_addr !== 16'd100 || fb_wdata !== 18'd7) begin
            err_cnt++; $display("FAIL host_write: got we=%b addr=%0d data=%h want 1/100/7", fb_we, fb_addr, fb_wdata); end
        host_valid = 1'b1; host_addr = 16'd38400; host_data = 18'd5;
        @(negedge clk);
        vec_cnt++; if (host_ready !== 1'b1) begin err_cnt++; $display("FAIL host_oob_ready: got %b want 1", host_ready); end
        tick(); host_valid = 1'b0;
        vec_cnt++; if (fb_we !== 1'b0) begin err_cnt++; $display("FAIL host_oob_write: got %b want 0", fb_we); end
        tick();
    endtask

    task automatic test_out_of_range();
        int any_we;
        any_we = 0;
        pix_we = 1'b1; pix_x = 8'd240; pix_y = 8'd0; pix_data = 18'd9;
        tick(); if (fb_we !== 1'b0) any_we++;
        pix_x = 8'd0; pix_y = 8'd160;
        tick(); if (fb_we !== 1'b0) any_we++;
        pix_we = 1'b0;
        repeat (4) begin tick(); if (fb_we !== 1'b0) any_we++; end
        vec_cnt++; if (any_we != 0) begin err_cnt++; $display("FAIL oob_pixel_write: got %0d writes want 0", any_we); end
        vec_cnt++; if (pix_overflow !== 1'b0) begin err_cnt++; $display("FAIL oob_overflow: got %b want 0", pix_overflow); end
    endtask

    task automatic test_contention();
        drive_contention(100);
        vec_cnt++; if (host_first != 20) begin err_cnt++; $display("FAIL cont_forced_grant: got cycle %0d want 20", host_first); end
        vec_cnt++; if (pix_overflow !== 1'b1) begin err_cnt++; $display("FAIL cont_overflow: got %b want 1", pix_overflow); end
        vec_cnt++; if (order_bad != 0) begin err_cnt++; $display("FAIL cont_order: got %0d bad want 0", order_bad); end
        vec_cnt++; if (pix_seen != 98) begin err_cnt++; $display("FAIL cont_pix_count: got %0d want 98", pix_seen); end
        vec_cnt++; if (host_seen != 5) begin err_cnt++; $display("FAIL cont_host_count: got %0d want 5", host_seen); end
    endtask

    task automatic test_reset_mid_run_and_clear();
        int   first_addr, cnt, busy_cnt, wr_cnt, bad;
        logic [17:0] first_data;
        bit   done;
        pix_we = 1'b1; pix_x = 8'd10; pix_y = 8'd0; pix_data = 18'd1;
        tick(); pix_x = 8'd11;
        tick(); pix_x = 8'd12;
        tick();
        #2; resetn = 1'b0; #1;
        vec_cnt++; if (fb_we !== 1'b0 || fb_addr !== 16'd0 || fb_wdata !== 18'd0) begin
            err_cnt++; $display("FAIL midrun_reset_fb: got we=%b addr=%0d data=%h want 0/0/0", fb_we, fb_addr, fb_wdata); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL midrun_reset_busy: got %b want 1", busy); end
        pix_we = 1'b0;
        @(negedge clk); resetn = 1'b1;
        first_addr = -1; first_data = '0; cnt = 0; done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            if (fb_we === 1'b1) begin
                if (first_addr < 0) begin first_addr = int'(fb_addr); first_data = fb_wdata; end
                if (fb_addr === 16'd999) done = 1;
            end
        end
        vec_cnt++; if (first_addr != 0 || first_data !== RESET_COLOR) begin
            err_cnt++; $display("FAIL midrun_refill_start: got %0d/%h want 0/20820", first_addr, first_data); end
        vec_cnt++; if (!done) begin err_cnt++; $display("FAIL midrun_refill_progress: got no addr 999 want addr 999"); end
        clear_req = 1'b1; clear_color = 18'd0;
        tick(); clear_req = 1'b0;
        busy_cnt = 0; wr_cnt = 0; bad = 0; done = 0;
        for (int i = 0; i < 40000 && !done; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (fb_we === 1'b1) begin
                if (fb_addr !== wr_cnt[15:0] || fb_wdata !== 18'd0) bad++;
                wr_cnt++;
            end else if (wr_cnt > 0) done = 1;
            if (!done) tick();
        end
        vec_cnt++; if (busy_cnt != 38400) begin err_cnt++; $display("FAIL clear_busy_cycles: got %0d want 38400", busy_cnt); end
        vec_cnt++; if (wr_cnt != 38400) begin err_cnt++; $display("FAIL clear_fill_count: got %0d want 38400", wr_cnt); end
        vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL clear_fill_sequence: got %0d bad want 0", bad); end
    endtask

    task automatic test_clear_in_run();
        drive_contention(100);
        vec_cnt++; if (pix_overflow !== 1'b1) begin err_cnt++; $display("FAIL run_clear_pre_overflow: got %b want 1", pix_overflow); end
        clear_req = 1'b1; clear_color = 18'h12345;
        tick(); clear_req = 1'b0;
        vec_cnt++; if (pix_overflow !== 1'b0) begin err_cnt++; $display("FAIL run_clear_overflow: got %b want 0", pix_overflow); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL run_clear_busy: got %b want 1", busy); end
        tick();
        vec_cnt++; if (fb_we !== 1'b1 || fb_addr !== 16'd0 || fb_wdata !== 18'h12345) begin
            err_cnt++; $display("FAIL run_clear_first: got we=%b addr=%0d data=%h want 1/0/12345", fb_we, fb_addr, fb_wdata); end
        tick();
        vec_cnt++; if (fb_we !== 1'b1 || fb_addr !== 16'd1 || fb_wdata !== 18'h12345) begin
            err_cnt++; $display("FAIL run_clear_second: got we=%b addr=%0d data=%h want 1/1/12345", fb_we, fb_addr, fb_wdata); end
    endtask

    initial begin
        resetn = 1'b0; clear_req = 1'b0; clear_color = '0;
        pix_we = 1'b0; pix_x = '0; pix_y = '0; pix_data = '0;
        host_valid = 1'b0; host_addr = '0; host_data = '0;
        test_reset();
        test_fill_after_reset();
        test_pixel_single();
        test_host_single();
        test_out_of_range();
        test_contention();
        test_reset_mid_run_and_clear();
        test_clear_in_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
